// File: rtl/lfsr_pkg.sv
// Package: lfsr_pkg
// Shared definitions for the LFSR pattern generator and its prescaler.
//  - mode_e     : step mode encoding (Fibonacci / Galois)
//  - DEF_TAPS5  : default 5-bit Fibonacci tap mask  (x^5 + x^3 + 1)
//  - DEF_GPOLY5 : default 5-bit Galois toggle mask  (same polynomial)
//  - clog2_min1 : counter width helper, never returns less than 1
package lfsr_pkg;

   typedef enum logic {
      MODE_FIB = 1'b0,
      MODE_GAL = 1'b1
   } mode_e;

   localparam logic [4:0] DEF_TAPS5  = 5'b10100;
   localparam logic [4:0] DEF_GPOLY5 = 5'b01001;

   function automatic int unsigned clog2_min1(input int unsigned v);
      int unsigned w;
      w = $clog2(v);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/lfsr_prsg_gen_tick_gen.sv
// Module: tick_gen
// Prescaler producing a single-cycle step strobe every PRESCALE enabled clocks.
// Ports:
//  clk   in  clock
//  rst   in  synchronous active-high reset, counter -> 0
//  en    in  count enable; en=0 freezes the counter
//  clr   in  synchronous clear, counter -> 0 (wins over counting)
//  step  out combinational strobe: en && counter at terminal value
module tick_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned PRESCALE = 2**25
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam int unsigned    CW   = clog2_min1(PRESCALE);
   localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   logic [CW-1:0] cnt;

   assign step = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/lfsr_prsg_gen.sv
// Module: lfsr_prsg_gen
// WIDTH-bit LFSR pseudo-random sequence generator, Fibonacci or Galois, stepped
// by an internal prescaler. Supports runtime seed load, all-zero lockup recovery
// and measurement of the sequence period (steps between returns to the seed).
// Ports:
//  clk      in   clock
//  rst      in   synchronous active-high reset
//  en       in   prescaler count enable; en=0 freezes prescaler and LFSR
//  mode     in   0=Fibonacci, 1=Galois, sampled at each step
//  load     in   one-cycle request to load seed_in (wins over a step)
//  seed_in  in   load value; zero is replaced by SEED and flags lockup
//  q        out  LFSR state
//  bit_out  out  q[WIDTH-1], serial stream
//  tick     out  pulse in the cycle a newly stepped q first appears
//  wrap     out  pulse in the cycle q returns to the reference seed
//  period   out  step count of the last completed sequence cycle
//  lockup   out  sticky: a zero state was replaced by SEED
module lfsr_prsg_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned          WIDTH    = 5,
   parameter logic [WIDTH-1:0]     TAPS     = WIDTH'(DEF_TAPS5),
   parameter logic [WIDTH-1:0]     GPOLY    = WIDTH'(DEF_GPOLY5),
   parameter logic [WIDTH-1:0]     SEED     = '1,
   parameter int unsigned          PRESCALE = 2**25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] q,
   output logic             bit_out,
   output logic             tick,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             lockup
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             step;
   logic             fb;
   logic [WIDTH-1:0] nq;
   logic [WIDTH-1:0] ref_seed;
   logic [WIDTH-1:0] step_cnt;

   // load also restarts the prescaler so the first step after a load is a full
   // prescale interval away
   tick_gen #(
      .PRESCALE(PRESCALE)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .step (step)
   );

   assign bit_out = q[WIDTH-1];

   always_comb begin
      fb = ^(q & TAPS);
      if (mode_e'(mode) == MODE_GAL)
         nq = {q[WIDTH-2:0], 1'b0} ^ ({WIDTH{q[WIDTH-1]}} & GPOLY);
      else
         nq = {q[WIDTH-2:0], fb};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= SEED;
         ref_seed <= SEED;
         step_cnt <= '0;
         period   <= '0;
         tick     <= 1'b0;
         wrap     <= 1'b0;
         lockup   <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (load) begin
            step_cnt <= '0;
            if (seed_in == '0) begin
               q        <= SEED;
               ref_seed <= SEED;
               lockup   <= 1'b1;
            end else begin
               q        <= seed_in;
               ref_seed <= seed_in;
               lockup   <= 1'b0;
            end
         end else if (step) begin
            tick <= 1'b1;
            if (q == '0) begin
               // defensive recovery; not reachable by stepping from non-zero
               q        <= SEED;
               step_cnt <= '0;
               lockup   <= 1'b1;
            end else begin
               q <= nq;
               if (nq == ref_seed) begin
                  wrap     <= 1'b1;
                  period   <= step_cnt + ONE;
                  step_cnt <= '0;
               end else begin
                  step_cnt <= step_cnt + ONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_prsg_gen.sv
// Testbench: tb_lfsr_prsg_gen
// Scoreboard bench for lfsr_prsg_gen (WIDTH=5). Stimulus pushes the expected
// q/wrap/period for each step; a monitor pops and compares on every tick.
// A second instance with PRESCALE=4 checks prescaler gating directly.
module tb_lfsr_prsg_gen;

   typedef struct {
      logic [4:0] q;
      logic       wrap;
      logic [4:0] period;
   } exp_t;

   localparam logic [4:0] TAPS5 = 5'b10100;
   localparam logic [4:0] GP5   = 5'b01001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, mode = 1'b0, load = 1'b0;
   logic [4:0] seed_in = '0;
   logic [4:0] q, period;
   logic       bit_out, tick, wrap, lockup;

   logic       en4 = 1'b0;
   logic [4:0] q4, period4;
   logic       bit_out4, tick4, wrap4, lockup4;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   logic fib_run = 1'b0;
   logic [31:0] seen = '0;

   always #5 clk = ~clk;

   lfsr_prsg_gen #(.WIDTH(5), .PRESCALE(1)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .seed_in(seed_in),
      .q(q), .bit_out(bit_out), .tick(tick), .wrap(wrap), .period(period), .lockup(lockup)
   );

   lfsr_prsg_gen #(.WIDTH(5), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .mode(1'b0), .load(1'b0), .seed_in(5'b00000),
      .q(q4), .bit_out(bit_out4), .tick(tick4), .wrap(wrap4), .period(period4), .lockup(lockup4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] fib_next(input logic [4:0] s);
      logic b;
      b = 1'b0;
      for (int i = 0; i < 5; i++)
         if (TAPS5[i]) b = b ^ s[i];
      return {s[3:0], b};
   endfunction

   function automatic logic [4:0] gal_next(input logic [4:0] s);
      logic [4:0] t;
      t = {s[3:0], 1'b0};
      if (s[4]) t = t ^ GP5;
      return t;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [4:0] v);
      seed_in = v;
      load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic drain(input string name);
      @(negedge clk);
      #1;
      chk(name, sb.size(), 0);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (tick) begin
            if (sb.size() == 0) begin
               chk("tick_unexpected", tick, 0);
            end else begin
               e = sb.pop_front();
               chk("q", q, e.q);
               chk("bit_out", bit_out, e.q[4]);
               chk("wrap", wrap, e.wrap);
               chk("period", period, e.period);
               if (fib_run) seen[q] = 1'b1;
            end
         end else begin
            chk("wrap_without_tick", wrap, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // stimulus
   initial begin
      logic [4:0] s;
      logic [4:0] hand_f [4];
      logic [4:0] hand_g [5];
      logic       en_pat [6];
      logic       tk_pat [6];
      logic [4:0] q4_pat [6];
      hand_f = '{5'b11110, 5'b11100, 5'b11000, 5'b10001};
      hand_g = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01001};
      en_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tk_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      q4_pat = '{5'h1f, 5'h1f, 5'h1f, 5'h1f, 5'h1e, 5'h1e};

      // reset
      cyc(); cyc();
      rst = 1'b0;
      chk("rst_q", q, 5'h1f);
      chk("rst_tick", tick, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_period", period, 0);
      chk("rst_lockup", lockup, 0);
      chk("rst_bit_out", bit_out, 1);

      // Fibonacci free run, 31 steps from 11111
      fib_run = 1'b1;
      mode = 1'b0;
      en = 1'b1;
      s = 5'h1f;
      for (int i = 0; i < 31; i++) begin
         s = (i < 4) ? hand_f[i] : fib_next(s);
         sb.push_back('{s, (i == 30), (i == 30) ? 5'd31 : 5'd0});
         cyc();
      end
      en = 1'b0;
      drain("fib_drain");
      fib_run = 1'b0;
      chk("fib_states_distinct", $countones(seen), 31);
      chk("fib_zero_not_visited", seen[0], 0);

      // Galois from loaded seed 00001
      mode = 1'b1;
      do_load(5'b00001);
      chk("gal_load_q", q, 5'b00001);
      chk("gal_load_tick", tick, 0);
      chk("gal_load_lockup", lockup, 0);
      en = 1'b1;
      s = 5'b00001;
      for (int i = 0; i < 31; i++) begin
         s = (i < 5) ? hand_g[i] : gal_next(s);
         sb.push_back('{s, (i == 30), 5'd31});
         cyc();
      end
      en = 1'b0;
      drain("gal_drain");

      // zero load and recovery
      do_load(5'b00000);
      chk("zero_load_q", q, 5'h1f);
      chk("zero_load_lockup", lockup, 1);
      chk("zero_load_tick", tick, 0);
      do_load(5'b00101);
      chk("nz_load_q", q, 5'b00101);
      chk("nz_load_lockup", lockup, 0);

      // load and step in the same cycle: load wins, no tick
      mode = 1'b0;
      en = 1'b1;
      seed_in = 5'b10110;
      load = 1'b1;
      cyc();
      load = 1'b0;
      en = 1'b0;
      chk("ld_step_q", q, 5'b10110);
      chk("ld_step_tick", tick, 0);
      chk("ld_step_wrap", wrap, 0);
      en = 1'b1;
      sb.push_back('{5'b01100, 1'b0, 5'd31});
      cyc();
      en = 1'b0;
      drain("ld_step_drain");

      // reset mid-sequence with a pending step and lockup set
      do_load(5'b00000);
      chk("pre_rst_lockup", lockup, 1);
      en = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      en = 1'b0;
      chk("mid_rst_q", q, 5'h1f);
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_wrap", wrap, 0);
      chk("mid_rst_period", period, 0);
      chk("mid_rst_lockup", lockup, 0);
      en = 1'b1;
      sb.push_back('{5'b11110, 1'b0, 5'd0});
      cyc();
      en = 1'b0;
      drain("rst_drain");

      // PRESCALE=4 instance: en 1,1,0,1,1 steps once after the 4th enabled cycle
      for (int i = 0; i < 6; i++) begin
         en4 = en_pat[i];
         cyc();
         chk($sformatf("ps4_tick_%0d", i), tick4, tk_pat[i]);
         chk($sformatf("ps4_q_%0d", i), q4, q4_pat[i]);
      end
      en4 = 1'b0;

      drain("final_drain");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
